// File: rtl/reg_bank.sv
// reg_bank: NREG x WIDTH register file with two combinational read ports,
// one synchronous write port and a per-register pending-write (lock)
// scoreboard used by the control unit to stall on hazards.
//
// Optional build macro REG_BANK_BYPASS_EN: when defined, a write in flight
// is forwarded combinationally to any read port addressing the same
// register, and that port's busy flag is cleared unless the same register
// is being re-locked in the same cycle.
module reg_bank #(
    parameter int WIDTH = 16,
    parameter int NREG  = 8,
    parameter int AW    = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_a_addr,
    output logic [WIDTH-1:0] rd_a_data,
    input  logic [AW-1:0]    rd_b_addr,
    output logic [WIDTH-1:0] rd_b_data,
    input  logic             lock_en,
    input  logic [AW-1:0]    lock_addr,
    output logic             busy_a,
    output logic             busy_b,
    output logic             any_busy
);

    // Flattened views of the per-register state, used by the read muxes.
    logic [WIDTH-1:0] data_all [NREG];
    logic [NREG-1:0]  lock_all;

    genvar gi;
    generate
        // The address must index the register array exactly.
        if ((NREG < 2) || ((NREG & (NREG - 1)) != 0) || (AW != $clog2(NREG))) begin : g_param_check
            $error("reg_bank: NREG must be a power of two >= 2 and AW == log2(NREG)");
        end

        for (gi = 0; gi < NREG; gi++) begin : g_reg
            logic [WIDTH-1:0] data_reg;
            logic             lock_reg;
            logic             wr_hit;
            logic             lock_hit;

            assign wr_hit   = wr_en   && (wr_addr   == AW'(gi));
            assign lock_hit = lock_en && (lock_addr == AW'(gi));

            // Register storage: written by the writeback stage.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    data_reg <= '0;
                end else if (wr_hit) begin
                    data_reg <= wr_data;
                end
            end

            // Lock bit: a new lock beats a retiring write to the same
            // register, since a new producer issues as the old one retires.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    lock_reg <= 1'b0;
                end else if (lock_hit) begin
                    lock_reg <= 1'b1;
                end else if (wr_hit) begin
                    lock_reg <= 1'b0;
                end
            end

            assign data_all[gi] = data_reg;
            assign lock_all[gi] = lock_reg;
        end
    endgenerate

    // Read port A: stored contents, optionally forwarded from the write port.
    always_comb begin
        rd_a_data = data_all[rd_a_addr];
        busy_a    = lock_all[rd_a_addr];
`ifdef REG_BANK_BYPASS_EN
        if (wr_en && (wr_addr == rd_a_addr)) begin
            rd_a_data = wr_data;
            if (!(lock_en && (lock_addr == rd_a_addr))) begin
                busy_a = 1'b0;
            end
        end
`endif
    end

    // Read port B: identical structure to port A.
    always_comb begin
        rd_b_data = data_all[rd_b_addr];
        busy_b    = lock_all[rd_b_addr];
`ifdef REG_BANK_BYPASS_EN
        if (wr_en && (wr_addr == rd_b_addr)) begin
            rd_b_data = wr_data;
            if (!(lock_en && (lock_addr == rd_b_addr))) begin
                busy_b = 1'b0;
            end
        end
`endif
    end

    // Global stall hint: any register with a pending write.
    assign any_busy = |lock_all;

endmodule

// File: tb/tb_reg_bank.sv
// Testbench for reg_bank: default 8x16 instance plus a 16x32 instance.
// A rule-level model (plain arrays) predicts every output; a compare
// process checks both instances on each falling edge, and directed
// steps add hand-computed literal expectations.
module tb_reg_bank;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    // Default instance signals
    logic        wr_en0 = 0, lock_en0 = 0;
    logic [2:0]  wr_addr0 = 0, lock_addr0 = 0, ra0 = 0, rb0 = 0;
    logic [15:0] wr_data0 = 0, rd_a0, rd_b0;
    logic        busy_a0, busy_b0, any0;

    // Wide instance signals
    logic        wr_en1 = 0, lock_en1 = 0;
    logic [3:0]  wr_addr1 = 0, lock_addr1 = 0, ra1 = 0, rb1 = 0;
    logic [31:0] wr_data1 = 0, rd_a1, rd_b1;
    logic        busy_a1, busy_b1, any1;

    reg_bank dut0 (
        .clk(clk), .rst(rst),
        .wr_en(wr_en0), .wr_addr(wr_addr0), .wr_data(wr_data0),
        .rd_a_addr(ra0), .rd_a_data(rd_a0),
        .rd_b_addr(rb0), .rd_b_data(rd_b0),
        .lock_en(lock_en0), .lock_addr(lock_addr0),
        .busy_a(busy_a0), .busy_b(busy_b0), .any_busy(any0)
    );

    reg_bank #(.WIDTH(32), .NREG(16), .AW(4)) dut1 (
        .clk(clk), .rst(rst),
        .wr_en(wr_en1), .wr_addr(wr_addr1), .wr_data(wr_data1),
        .rd_a_addr(ra1), .rd_a_data(rd_a1),
        .rd_b_addr(rb1), .rd_b_data(rd_b1),
        .lock_en(lock_en1), .lock_addr(lock_addr1),
        .busy_a(busy_a1), .busy_b(busy_b1), .any_busy(any1)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;
    logic cmp_en  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    // Model state
    logic [15:0] m0 [8];
    logic        ml0 [8];
    logic [31:0] m1 [16];
    logic        ml1 [16];

    // Model update: write stores data and frees the lock; a lock applied
    // afterwards in the same edge wins.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 8; i++) begin m0[i] = 0; ml0[i] = 0; end
            for (int i = 0; i < 16; i++) begin m1[i] = 0; ml1[i] = 0; end
        end else begin
            if (wr_en0) begin m0[wr_addr0] = wr_data0; ml0[wr_addr0] = 0; end
            if (lock_en0) ml0[lock_addr0] = 1;
            if (wr_en1) begin m1[wr_addr1] = wr_data1; ml1[wr_addr1] = 0; end
            if (lock_en1) ml1[lock_addr1] = 1;
        end
    end

    // Expected read data / busy for a given address, from model + live inputs.
    function automatic logic [15:0] exp_d0(input logic [2:0] a);
        logic [15:0] d;
        d = m0[a];
`ifdef REG_BANK_BYPASS_EN
        if (wr_en0 && wr_addr0 == a) d = wr_data0;
`endif
        return d;
    endfunction

    function automatic logic exp_b0(input logic [2:0] a);
        logic b;
        b = ml0[a];
`ifdef REG_BANK_BYPASS_EN
        if (wr_en0 && wr_addr0 == a && !(lock_en0 && lock_addr0 == a)) b = 0;
`endif
        return b;
    endfunction

    function automatic logic [31:0] exp_d1(input logic [3:0] a);
        logic [31:0] d;
        d = m1[a];
`ifdef REG_BANK_BYPASS_EN
        if (wr_en1 && wr_addr1 == a) d = wr_data1;
`endif
        return d;
    endfunction

    function automatic logic exp_b1(input logic [3:0] a);
        logic b;
        b = ml1[a];
`ifdef REG_BANK_BYPASS_EN
        if (wr_en1 && wr_addr1 == a && !(lock_en1 && lock_addr1 == a)) b = 0;
`endif
        return b;
    endfunction

    // Cycle-by-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (cmp_en) begin
            logic a0, a1;
            a0 = 0; a1 = 0;
            for (int i = 0; i < 8; i++) a0 |= ml0[i];
            for (int i = 0; i < 16; i++) a1 |= ml1[i];
            check("m0_rd_a", 32'(rd_a0), 32'(exp_d0(ra0)));
            check("m0_rd_b", 32'(rd_b0), 32'(exp_d0(rb0)));
            check("m0_busy_a", 32'(busy_a0), 32'(exp_b0(ra0)));
            check("m0_busy_b", 32'(busy_b0), 32'(exp_b0(rb0)));
            check("m0_any", 32'(any0), 32'(a0));
            check("m1_rd_a", rd_a1, exp_d1(ra1));
            check("m1_rd_b", rd_b1, exp_d1(rb1));
            check("m1_busy_a", 32'(busy_a1), 32'(exp_b1(ra1)));
            check("m1_busy_b", 32'(busy_b1), 32'(exp_b1(rb1)));
            check("m1_any", 32'(any1), 32'(a1));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset state
        step();
        step();
        check("rst_rd_a", 32'(rd_a0), 32'h0);
        check("rst_busy_a", 32'(busy_a0), 32'h0);
        check("rst_any", 32'(any0), 32'h0);
        rst = 0;
        cmp_en = 1;

        // Fill every register with A000+i
        for (int i = 0; i < 8; i++) begin
            wr_en0 = 1; wr_addr0 = 3'(i); wr_data0 = 16'hA000 + 16'(i);
            step();
        end
        wr_en0 = 0;

        // Sweep all read-address pairs
        for (int a = 0; a < 8; a++) begin
            for (int b = 0; b < 8; b++) begin
                ra0 = 3'(a); rb0 = 3'(b);
                #1;
                if (a == b) check("same_addr", 32'(rd_a0), 32'(rd_b0));
                if (b == 0) check("sweep_a", 32'(rd_a0), 32'h0000A000 + 32'(a));
                step();
            end
        end

        // Lock reg 3, then retire it with a write
        lock_en0 = 1; lock_addr0 = 3; ra0 = 3;
        step();
        lock_en0 = 0;
        check("lock3_busy", 32'(busy_a0), 32'h1);
        check("lock3_any", 32'(any0), 32'h1);
        wr_en0 = 1; wr_addr0 = 3; wr_data0 = 16'h00FF;
        step();
        wr_en0 = 0;
        check("wr3_busy", 32'(busy_a0), 32'h0);
        check("wr3_any", 32'(any0), 32'h0);
        check("wr3_data", 32'(rd_a0), 32'h00FF);

        // Same-address lock + write: lock wins, data still written
        wr_en0 = 1; wr_addr0 = 6; wr_data0 = 16'h0BEE; lock_en0 = 1; lock_addr0 = 6;
        step();
        wr_en0 = 0; lock_en0 = 0; ra0 = 6;
        #1;
        check("lw6_data", 32'(rd_a0), 32'h0BEE);
        check("lw6_busy", 32'(busy_a0), 32'h1);
        step();

        // Different addresses: lock 2, write 4
        wr_en0 = 1; wr_addr0 = 4; wr_data0 = 16'h1111; lock_en0 = 1; lock_addr0 = 2;
        step();
        wr_en0 = 0; lock_en0 = 0; ra0 = 2; rb0 = 4;
        #1;
        check("l2_busy", 32'(busy_a0), 32'h1);
        check("w4_busy", 32'(busy_b0), 32'h0);
        check("w4_data", 32'(rd_b0), 32'h1111);
        step();

        // Write-through visibility on port B
        wr_en0 = 1; wr_addr0 = 1; wr_data0 = 16'hCAFE; rb0 = 1;
        #1;
`ifdef REG_BANK_BYPASS_EN
        check("byp_same_cycle", 32'(rd_b0), 32'hCAFE);
`else
        check("byp_same_cycle", 32'(rd_b0), 32'hA001);
`endif
        step();
        wr_en0 = 0;
        #1;
        check("byp_next_cycle", 32'(rd_b0), 32'hCAFE);
        step();

        // Async reset mid-cycle after writing reg 5
        wr_en0 = 1; wr_addr0 = 5; wr_data0 = 16'h1234; ra0 = 5;
        step();
        wr_en0 = 0;
        #1;
        check("pre_rst_data", 32'(rd_a0), 32'h1234);
        check("pre_rst_any", 32'(any0), 32'h1);
        #1;
        rst = 1;
        #1;
        check("async_rst_data", 32'(rd_a0), 32'h0);
        check("async_rst_any", 32'(any0), 32'h0);
        step();
        rst = 0;
        step();

        // Wide instance: lock/unlock and write of the top register
        lock_en1 = 1; lock_addr1 = 15; ra1 = 15; rb1 = 0;
        step();
        lock_en1 = 0;
        check("w_lock15_busy", 32'(busy_a1), 32'h1);
        check("w_lock15_any", 32'(any1), 32'h1);
        wr_en1 = 1; wr_addr1 = 15; wr_data1 = 32'hDEADBEEF;
        step();
        wr_en1 = 0;
        check("w_rd15", rd_a1, 32'hDEADBEEF);
        check("w_busy15", 32'(busy_a1), 32'h0);
        check("w_any", 32'(any1), 32'h0);
        check("w_rd0", rd_b1, 32'h0);
        step();
        step();

        cmp_en = 0;
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
